// File: rtl/i3c_tb_arbiter_if.sv
// To-bus byte channel between the requesters, the arbiter and the I3C slave wrapper.
// master is the arbiter's view; slave is the requester/wrapper side.
interface i3c_tb_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   req_abort;
    logic [NREQ-1:0]   grant;
    logic              bus_stop;
    logic              tb_data_valid;
    logic [7:0]        tb_datab;
    logic              tb_end;
    logic              tb_datab_ack;
    logic              underrun_err;
    logic              err_clr;

    modport master (
        input  req_valid, req_data, req_last, bus_stop, tb_datab_ack, err_clr,
        output req_ack, req_abort, grant, tb_data_valid, tb_datab, tb_end, underrun_err
    );

    modport slave (
        output req_valid, req_data, req_last, bus_stop, tb_datab_ack, err_clr,
        input  req_ack, req_abort, grant, tb_data_valid, tb_datab, tb_end, underrun_err
    );
endinterface

// File: rtl/i3c_tb_arbiter.sv
// Round-robin arbiter/sequencer sharing the wrapper's to-bus byte channel between NREQ requesters.
// An owner keeps the channel for a whole message; STOP or a stall timeout aborts it.
module i3c_tb_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned STALL_TO = 64
) (
    input logic              CLK,
    input logic              RSTn,
    i3c_tb_arbiter_if.master bus
);
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   own_q, own_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] abort_q, abort_d;
    logic [7:0]      data_q, data_d;
    logic            end_q, end_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [9:0]      stall_q, stall_d;

    logic [IW-1:0]   arb_idx, cand, cap_idx;
    logic            arb_hit, cap, rel, err_set;
    logic [7:0]      req_byte [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_byte
        assign req_byte[gi] = bus.req_data[8*gi +: 8];
    end

    function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] i);
        if (32'(i) == NREQ - 1) return '0;
        return i + 1'b1;
    endfunction

    // First requesting index at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(rr_ptr_q) + k) % NREQ);
            if (!arb_hit && bus.req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        own_d    = own_q;
        grant_d  = grant_q;
        data_d   = data_q;
        end_d    = end_q;
        valid_d  = valid_q;
        stall_d  = stall_q;
        ack_d    = '0;
        abort_d  = '0;
        err_set  = 1'b0;
        cap      = 1'b0;
        rel      = 1'b0;
        cap_idx  = own_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_hit) begin
                    cap              = 1'b1;
                    cap_idx          = arb_idx;
                    own_d            = arb_idx;
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                end
            end
            ST_XFER: begin
                // The ack is honoured before STOP: a consumed last byte completes normally.
                if (bus.tb_datab_ack) begin
                    if (end_q) begin
                        rel = 1'b1;
                    end else if (bus.bus_stop) begin
                        rel            = 1'b1;
                        abort_d[own_q] = 1'b1;
                    end else if (bus.req_valid[own_q]) begin
                        cap = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        stall_d = '0;
                        state_d = ST_WAIT;
                    end
                end else if (bus.bus_stop) begin
                    rel            = 1'b1;
                    abort_d[own_q] = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.bus_stop) begin
                    rel            = 1'b1;
                    abort_d[own_q] = 1'b1;
                end else if (bus.req_valid[own_q]) begin
                    cap = 1'b1;
                end else if (stall_q == 10'(STALL_TO - 1)) begin
                    rel            = 1'b1;
                    abort_d[own_q] = 1'b1;
                    err_set        = 1'b1;
                end else begin
                    stall_d = stall_q + 10'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cap) begin
            data_d           = req_byte[cap_idx];
            end_d            = bus.req_last[cap_idx];
            ack_d[cap_idx]   = 1'b1;
            valid_d          = 1'b1;
            state_d          = ST_XFER;
        end

        if (rel) begin
            grant_d  = '0;
            valid_d  = 1'b0;
            rr_ptr_d = inc_idx(own_q);
            state_d  = ST_IDLE;
            if (|abort_d) end_d = 1'b0;
        end

        err_d = err_set | (err_q & ~bus.err_clr);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            own_q    <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            abort_q  <= '0;
            data_q   <= '0;
            end_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            own_q    <= own_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            abort_q  <= abort_d;
            data_q   <= data_d;
            end_q    <= end_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.req_ack       = ack_q;
    assign bus.req_abort     = abort_q;
    assign bus.grant         = grant_q;
    assign bus.tb_data_valid = valid_q;
    assign bus.tb_datab      = data_q;
    assign bus.tb_end        = end_q;
    assign bus.underrun_err  = err_q;
endmodule

// File: doc/i3c_tb_arbiter.md
# i3c_tb_arbiter

Round-robin arbiter and sequencer for the to-bus (read-data) byte interface of the I3C slave wrapper. It shares the wrapper's single tb_data_valid/tb_datab/tb_end/tb_datab_ack channel between NREQ on-chip requesters, such as a PMIC register-read path and a status/telemetry path. Once granted, a requester keeps the channel for one complete message, which ends with its last byte or when the bus STOPs. The block also detects requester underrun and drives the wrapper's handshake cycle-exactly.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- STALL_TO, 64: CLK cycles a granted requester may stall mid-message before it is aborted, 1..1023.

Ports:
- CLK  in  1  block clock; the wrapper's to-bus handshake is synchronous to it.
- RSTn  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  requester i has a byte on req_data[8i+7:8i].
- req_data  in  8*NREQ  byte per requester.
- req_last  in  NREQ  the presented byte is the last byte of the message.
- req_ack  out  NREQ  one-cycle pop pulse; the byte was captured this cycle.
- req_abort  out  NREQ  one-cycle pulse; the message was terminated early (bus STOP or stall timeout).
- grant  out  NREQ  one-hot current owner; all zero when idle.
- bus_stop  in  1  one-cycle pulse from the wrapper's STOP detect (int_in_STOP rising), synchronous to CLK.
- tb_data_valid  out  1  held byte is valid to the wrapper.
- tb_datab  out  8  held byte.
- tb_end  out  1  held byte is the last of the message; only meaningful while tb_data_valid=1.
- tb_datab_ack  in  1  one-cycle pulse; the wrapper consumed the held byte.
- underrun_err  out  1  sticky; set on any stall-timeout abort.
- err_clr  in  1  clears underrun_err.

## Operation
- Registered state:
  - FSM state: IDLE, XFER, WAIT.
  - rr_ptr: log2(NREQ) bits.
  - grant: one-hot.
  - Holding register: tb_datab and tb_end.
  - stall_cnt: 10 bits.
- Reset values: all outputs 0, FSM=IDLE, rr_ptr=0, stall_cnt=0.
- Arbitration, in IDLE only:
  - Scan req_valid starting at index rr_ptr and wrapping modulo NREQ.
  - The first set bit wins, g.
  - Same cycle: grant<=onehot(g), capture req_data[g] and req_last[g], pulse req_ack[g], tb_data_valid<=1, go to XFER.
- XFER (byte held, waiting for tb_datab_ack):
  - If the held byte has tb_end=1: complete the message. Clear grant and tb_data_valid, set rr_ptr<=(g+1)%NREQ, go to IDLE.
  - Else if req_valid[g]=1: capture the next byte in the same cycle, pulse req_ack[g], keep tb_data_valid=1 (back-to-back, no bubble).
  - Else: tb_data_valid<=0, stall_cnt<=0, go to WAIT.
  - Without ack: hold all state. tb_datab and tb_end must not change while tb_data_valid=1.
- WAIT (grant held, no byte):
  - When req_valid[g]=1: capture it, pulse req_ack, tb_data_valid<=1, go to XFER.
  - Otherwise stall_cnt increments.
  - When stall_cnt reaches STALL_TO-1 without data: pulse req_abort[g], set underrun_err, clear grant, set rr_ptr<=(g+1)%NREQ, go to IDLE.
- bus_stop in XFER or WAIT:
  - Pulse req_abort[g], clear tb_data_valid, tb_end and grant, set rr_ptr<=(g+1)%NREQ, go to IDLE.
  - The captured-but-unsent byte is discarded.
  - bus_stop in IDLE has no effect.
- Ack and bus_stop in the same cycle:
  - The ack is honoured first.
  - If the held byte was last, this is a normal completion with no abort.
  - Otherwise the STOP abort applies and no new byte is captured.
- Stall timeout and req_valid in the same cycle: the data wins and there is no abort.
- err_clr and a set condition in the same cycle: the set wins.
- req_ack is never asserted for a non-granted requester. At most one req_ack or req_abort bit is set per cycle.
- A requester that deasserts req_valid before its ack is an integration error; no recovery is required.

## Timing
- Grant latency: a request seen in IDLE in cycle N gives grant, tb_data_valid and req_ack in cycle N+1.
- Back-to-back bytes: the next byte is visible the cycle after tb_datab_ack.
- Release to next grant: the owner's final ack in cycle N returns the block to IDLE in N+1. The next grant is visible in N+2 at the earliest.
- Stall abort occurs exactly STALL_TO cycles after entry to WAIT.
- Reset mid-message: everything returns to reset values on the next CLK edge. No req_abort is issued.

## Test plan
- Single requester, 3-byte message 0x55,0xAA,0x0F with last on 0x0F, wrapper acks every 4 cycles. Required: tb_datab sequence 55/AA/0F, tb_end only with 0F, three req_ack pulses, grant cleared after the third ack, rr_ptr=1.
- Requesters 0 and 2 both request continuously with 1-byte messages. Required: grants alternate 0,2,0,2. Requester 1 requests mid-run and is served in rotation order after the current owner.
- Requester 1 stalls after its first byte with STALL_TO=8. Required: tb_data_valid drops after the ack, req_abort[1] pulses 8 cycles after entering WAIT, underrun_err=1, then cleared by err_clr.
- bus_stop during WAIT and during XFER. Required: req_abort pulses, tb_data_valid=0 the next cycle, no extra req_ack. A subsequent request is granted normally.
- bus_stop coincident with the ack of the last byte. Required: normal completion, no req_abort. The same coincidence on a non-last byte requires req_abort.
- RSTn low mid-message for 1 cycle. Required: all outputs 0, rr_ptr=0, and the next arbitration starts at requester 0.
